// File: rtl/instr_issue_queue_pkg.sv
// Shared widths, opcode constants and instruction word layout for the issue stage.
package instr_issue_queue_pkg;

    localparam int OPC_W  = 5;
    localparam int REG_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [OPC_W-1:0] OPC_NOP = 5'd0;

    // Instruction word as presented to the fetch stage: {opcode, s1, s2, dest, ime_data}
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  s1;
        logic [REG_W-1:0]  s2;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] ime_data;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

    // What the issue stage does with the FIFO head on an advance strobe
    typedef enum logic [1:0] {
        ISSUE_EMPTY,
        ISSUE_BUBBLE,
        ISSUE_POP
    } issue_kind_e;

endpackage

// File: rtl/instr_issue_queue_if.sv
// Host-side push handshake and fetch-side issue outputs of the issue queue.
interface instr_issue_queue_if #(
    parameter int DEPTH = 8
);
    import instr_issue_queue_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    // host side
    logic              instr_valid_in;
    logic              instr_ready_out;
    logic [OPC_W-1:0]  opcode_host_in;
    logic [REG_W-1:0]  s1_host_in;
    logic [REG_W-1:0]  s2_host_in;
    logic [REG_W-1:0]  dest_host_in;
    logic [DATA_W-1:0] ime_data_host_in;

    // pipeline control
    logic              issue_en_in;
    logic              flush_in;

    // fetch side
    logic [OPC_W-1:0]  opcode_out;
    logic [REG_W-1:0]  s1_out;
    logic [REG_W-1:0]  s2_out;
    logic [REG_W-1:0]  dest_out;
    logic [DATA_W-1:0] ime_data_out;
    logic              issue_valid_out;
    logic [15:0]       bubble_count_out;
    logic [LVL_W-1:0]  level_out;

    modport master (
        output instr_valid_in, opcode_host_in, s1_host_in, s2_host_in, dest_host_in,
               ime_data_host_in, issue_en_in, flush_in,
        input  instr_ready_out, opcode_out, s1_out, s2_out, dest_out, ime_data_out,
               issue_valid_out, bubble_count_out, level_out
    );

    modport slave (
        input  instr_valid_in, opcode_host_in, s1_host_in, s2_host_in, dest_host_in,
               ime_data_host_in, issue_en_in, flush_in,
        output instr_ready_out, opcode_out, s1_out, s2_out, dest_out, ime_data_out,
               issue_valid_out, bubble_count_out, level_out
    );

endinterface

// File: rtl/instr_issue_queue_sync_fifo.sv
// Synchronous FIFO with registered level; head is read from storage at the read pointer,
// so a word written on one edge is visible as head only after that edge (no fall-through).
module sync_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage write; contents need no reset since level gates visibility
    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; flush empties the queue like reset does
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue stage: buffers host words and issues one instruction or NOP bubble
// per pipeline-advance strobe, stalling on RAW hazards against recent issues.
module instr_issue_queue
    import instr_issue_queue_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int HAZARD_WINDOW = 2
) (
    input logic                 sys_clk,
    input logic                 reset_n,
    instr_issue_queue_if.slave  bus
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    instr_t                              w_wdata;
    instr_t                              w_head;
    logic [LVL_W-1:0]                    w_level;
    logic                                w_full;
    logic                                w_empty;
    logic                                w_push;
    logic                                w_pop;
    logic                                w_hazard;
    issue_kind_e                         w_kind;

    logic [HAZARD_WINDOW-1:0]            r_hist_wr;
    logic [HAZARD_WINDOW-1:0][REG_W-1:0] r_hist_dest;
    instr_t                              r_out;
    logic                                r_valid;
    logic [15:0]                         r_bubbles;

    assign w_wdata = '{opcode:   bus.opcode_host_in,
                       s1:       bus.s1_host_in,
                       s2:       bus.s2_host_in,
                       dest:     bus.dest_host_in,
                       ime_data: bus.ime_data_host_in};

    assign w_push = bus.instr_valid_in && !w_full && !bus.flush_in;
    assign w_pop  = bus.issue_en_in && !bus.flush_in && (w_kind == ISSUE_POP);

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst_n (reset_n),
        .i_flush (bus.flush_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // RAW check of both head sources against every live history entry
    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned i = 0; i < HAZARD_WINDOW; i++) begin
            if (r_hist_wr[i] &&
                ((r_hist_dest[i] == w_head.s1) || (r_hist_dest[i] == w_head.s2))) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Classify what an advance strobe would do this cycle
    always_comb begin
        w_kind = ISSUE_POP;
        if (w_empty) begin
            w_kind = ISSUE_EMPTY;
        end else if (w_hazard) begin
            w_kind = ISSUE_BUBBLE;
        end
    end

    // Output registers, hazard history shift and bubble counter
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_bubbles   <= '0;
            r_hist_wr   <= '0;
            r_hist_dest <= '0;
        end else if (bus.flush_in) begin
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_hist_wr <= '0;
        end else if (bus.issue_en_in) begin
            for (int unsigned i = 1; i < HAZARD_WINDOW; i++) begin
                r_hist_wr[i]   <= r_hist_wr[i-1];
                r_hist_dest[i] <= r_hist_dest[i-1];
            end
            case (w_kind)
                ISSUE_POP: begin
                    r_out          <= w_head;
                    r_valid        <= 1'b1;
                    r_hist_wr[0]   <= (w_head.opcode != OPC_NOP);
                    r_hist_dest[0] <= w_head.dest;
                end
                ISSUE_BUBBLE: begin
                    r_out          <= '0;
                    r_valid        <= 1'b0;
                    r_bubbles      <= r_bubbles + 1'b1;
                    r_hist_wr[0]   <= 1'b0;
                    r_hist_dest[0] <= '0;
                end
                default: begin
                    r_out          <= '0;
                    r_valid        <= 1'b0;
                    r_hist_wr[0]   <= 1'b0;
                    r_hist_dest[0] <= '0;
                end
            endcase
        end
    end

    assign bus.opcode_out       = r_out.opcode;
    assign bus.s1_out           = r_out.s1;
    assign bus.s2_out           = r_out.s2;
    assign bus.dest_out         = r_out.dest;
    assign bus.ime_data_out     = r_out.ime_data;
    assign bus.issue_valid_out  = r_valid;
    assign bus.bubble_count_out = r_bubbles;
    assign bus.level_out        = w_level;
    assign bus.instr_ready_out  = !w_full;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: stimulus queues hand-computed issue results,
// a monitor compares them after every advance strobe.
module tb_instr_issue_queue;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic        v;
        logic [4:0]  op;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  d;
        logic [31:0] imm;
        logic [15:0] bc;
    } exp_t;

    exp_t exp_q[$];

    instr_issue_queue_if #(.DEPTH(8)) ifc ();

    instr_issue_queue #(
        .DEPTH         (8),
        .HAZARD_WINDOW (2)
    ) dut (
        .sys_clk (clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_issue(input int v, input int op, input int s1, input int s2,
                                input int d, input int imm, input int bc);
        exp_t e;
        e.v = v[0]; e.op = op[4:0]; e.s1 = s1[3:0]; e.s2 = s2[3:0];
        e.d = d[3:0]; e.imm = imm; e.bc = bc[15:0];
        exp_q.push_back(e);
    endtask

    task automatic set_fields(input int op, input int s1, input int s2, input int d, input int imm);
        ifc.opcode_host_in   = op[4:0];
        ifc.s1_host_in       = s1[3:0];
        ifc.s2_host_in       = s2[3:0];
        ifc.dest_host_in     = d[3:0];
        ifc.ime_data_host_in = imm;
    endtask

    task automatic push(input int op, input int s1, input int s2, input int d, input int imm);
        set_fields(op, s1, s2, d, imm);
        ifc.instr_valid_in = 1'b1;
        @(negedge clk);
        ifc.instr_valid_in = 1'b0;
    endtask

    task automatic strobe();
        ifc.issue_en_in = 1'b1;
        @(negedge clk);
        ifc.issue_en_in = 1'b0;
    endtask

    task automatic do_flush();
        ifc.flush_in = 1'b1;
        @(negedge clk);
        ifc.flush_in = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag, input int bc);
        check({tag, "_opcode"}, 64'(ifc.opcode_out), 64'd0);
        check({tag, "_regs"}, 64'({ifc.s1_out, ifc.s2_out, ifc.dest_out}), 64'd0);
        check({tag, "_imm"}, 64'(ifc.ime_data_out), 64'd0);
        check({tag, "_valid"}, 64'(ifc.issue_valid_out), 64'd0);
        check({tag, "_bubbles"}, 64'(ifc.bubble_count_out), 64'(bc));
        check({tag, "_level"}, 64'(ifc.level_out), 64'd0);
        check({tag, "_ready"}, 64'(ifc.instr_ready_out), 64'd1);
    endtask

    // Monitor: after each advance strobe, compare the registered outputs with the next expectation
    always @(posedge clk) begin
        if (reset_n && ifc.issue_en_in && !ifc.flush_in) begin
            #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected actual=strobe required=no_strobe");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({ifc.issue_valid_out, ifc.opcode_out, ifc.s1_out, ifc.s2_out, ifc.dest_out,
                     ifc.ime_data_out, ifc.bubble_count_out} !==
                    {e.v, e.op, e.s1, e.s2, e.d, e.imm, e.bc}) begin
                    bad++;
                    $display("FAIL issue actual=v%b op%0h s%0h/%0h d%0h imm%0h bc%0d required=v%b op%0h s%0h/%0h d%0h imm%0h bc%0d",
                             ifc.issue_valid_out, ifc.opcode_out, ifc.s1_out, ifc.s2_out,
                             ifc.dest_out, ifc.ime_data_out, ifc.bubble_count_out,
                             e.v, e.op, e.s1, e.s2, e.d, e.imm, e.bc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n              = 1'b0;
        ifc.instr_valid_in   = 1'b0;
        ifc.issue_en_in      = 1'b0;
        ifc.flush_in         = 1'b0;
        set_fields(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 0);
        reset_n = 1'b1;
        @(negedge clk);

        // three independent instructions, strobes every 4 cycles, then an empty NOP
        push(1, 4, 5, 1, 32'h11);
        push(2, 6, 7, 2, 32'h22);
        push(3, 8, 9, 3, 32'h33);
        check("level_after_3", 64'(ifc.level_out), 64'd3);
        expect_issue(1, 1, 4, 5, 1, 32'h11, 0); strobe(); repeat (3) @(negedge clk);
        expect_issue(1, 2, 6, 7, 2, 32'h22, 0); strobe(); repeat (3) @(negedge clk);
        expect_issue(1, 3, 8, 9, 3, 32'h33, 0); strobe(); repeat (3) @(negedge clk);
        expect_issue(0, 0, 0, 0, 0, 0, 0);      strobe(); repeat (3) @(negedge clk);
        check("level_drained", 64'(ifc.level_out), 64'd0);

        // RAW hazard: dependent word waits two bubbles
        push(1, 1, 2, 5, 32'h44);
        push(4, 5, 0, 6, 32'h55);
        expect_issue(1, 1, 1, 2, 5, 32'h44, 0); strobe();
        expect_issue(0, 0, 0, 0, 0, 0, 1);      strobe();
        expect_issue(0, 0, 0, 0, 0, 0, 2);      strobe();
        expect_issue(1, 4, 5, 0, 6, 32'h55, 2); strobe();
        check("bubbles_after_hazard", 64'(ifc.bubble_count_out), 64'd2);

        // fill past DEPTH: only 8 accepted
        ifc.instr_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_fields(7, 10, 11, 12, i);
            @(negedge clk);
        end
        ifc.instr_valid_in = 1'b0;
        check("full_ready", 64'(ifc.instr_ready_out), 64'd0);
        check("full_level", 64'(ifc.level_out), 64'd8);
        expect_issue(1, 7, 10, 11, 12, 0, 2); strobe();
        check("after_pop_ready", 64'(ifc.instr_ready_out), 64'd1);
        check("after_pop_level", 64'(ifc.level_out), 64'd7);

        // push and pop together at level 7
        set_fields(8, 10, 11, 13, 32'h99);
        ifc.instr_valid_in = 1'b1;
        expect_issue(1, 7, 10, 11, 12, 1, 2);
        strobe();
        ifc.instr_valid_in = 1'b0;
        check("pushpop_level", 64'(ifc.level_out), 64'd7);

        // flush a nearly full queue
        do_flush();
        check_idle_outputs("flush1", 2);

        // flush with pending hazard; same sources then issue immediately
        push(1, 0, 0, 14, 32'h66);
        expect_issue(1, 1, 0, 0, 14, 32'h66, 2); strobe();
        for (int j = 0; j < 5; j++) push(2, 14, 15, 3, j);
        check("level_before_flush2", 64'(ifc.level_out), 64'd5);
        do_flush();
        check_idle_outputs("flush2", 2);
        push(2, 14, 15, 3, 32'hAB);
        expect_issue(1, 2, 14, 15, 3, 32'hAB, 2); strobe();

        // reset mid-stream with 4 queued words and bubble count 3
        for (int k = 0; k < 4; k++) push(1, 3, 0, 4, 32'h70 + k);
        expect_issue(0, 0, 0, 0, 0, 0, 3); strobe();
        check("pre_reset_level", 64'(ifc.level_out), 64'd4);
        check("pre_reset_bubbles", 64'(ifc.bubble_count_out), 64'd3);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset", 0);
        reset_n = 1'b1;
        @(negedge clk);
        expect_issue(0, 0, 0, 0, 0, 0, 0); strobe();
        check("post_reset_level", 64'(ifc.level_out), 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
